framebuffer_arbiter: RTL
========================

FRAMEBUFFER_ARBITER -- requirements
Module: framebuffer_arbiter

Interface
REQ-001 SHALL have parameter CLEAR_VALUE, default 8'h00, the byte written to every location by a clear sweep.
REQ-002 SHALL have port clk  input  1  sole clock; all logic on posedge clk.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port disp_addr  input  10  byte address from the screen driver's pixelAddress.
REQ-005 SHALL have port disp_data  output  8  front-bank byte at disp_addr, to the screen driver's pixelData.
REQ-006 SHALL have ports wra_valid, wra_addr, wra_data  input  1/10/8  write requester A: valid, byte address, byte.
REQ-007 SHALL have port wra_ready  output  1  requester A write accepted this cycle.
REQ-008 SHALL have ports wrb_valid, wrb_addr, wrb_data, wrb_ready  with the same widths, directions and meanings for requester B.
REQ-009 SHALL have port clear_req  input  1  one-cycle request to fill the back bank with CLEAR_VALUE.
REQ-010 SHALL have port clear_busy  output  1  clear sweep in progress.
REQ-011 SHALL have port swap_req  input  1  one-cycle request to exchange front and back banks.
REQ-012 SHALL have port swap_pending  output  1  swap requested, not yet applied.
REQ-013 SHALL have port front_bank  output  1  index of the bank currently displayed.

Function
REQ-014 SHALL hold two 1024x8 banks; display reads front_bank only; writes and clears target back bank (~front_bank) only.
REQ-015 SHALL register disp_data: value at disp_addr sampled at edge N appears after edge N (1-cycle latency), from the bank that is front at edge N.
REQ-016 SHALL implement states IDLE and CLEAR; reset enters IDLE.
REQ-017 IDLE: wra_ready/wrb_ready SHALL be combinational grants; a write commits to back bank when valid&&ready at the clock edge.
REQ-018 SHALL grant at most one requester per cycle; a lone valid requester SHALL be granted that cycle.
REQ-019 Both valid: grant SHALL go to the requester not granted on the most recent transfer (round robin); last_grant updates only on a transfer.
REQ-020 clear_req in IDLE SHALL move to CLEAR next edge; clear_req has priority over writes, so both readies are 0 in the cycle clear_req is high.
REQ-021 CLEAR: SHALL write CLEAR_VALUE to addresses 0..1023, one per cycle ascending, 1024 cycles, then return to IDLE; clear_busy=1 exactly during those 1024 cycles.
REQ-022 CLEAR: both readies SHALL be 0; clear_req SHALL be ignored.
REQ-023 swap_req SHALL set swap_pending next edge; repeat swap_req while pending has no extra effect.
REQ-024 Frame boundary SHALL be detected as registered previous disp_addr == 1023 and current disp_addr == 0.
REQ-025 At a boundary with swap_pending=1 and state IDLE, SHALL toggle front_bank and clear swap_pending on the same edge.
REQ-026 Boundary during CLEAR SHALL NOT swap; swap_pending SHALL stay set until the next boundary seen in IDLE.
REQ-027 swap_req coincident with a qualifying boundary SHALL only set swap_pending; swap occurs at a later boundary.
REQ-028 A write accepted on the swap edge SHALL commit to the pre-swap back bank.
REQ-029 disp_addr non-wrapping jumps (e.g. 5 -> 0) SHALL NOT count as boundaries.

Reset
REQ-030 rst=1 at an edge SHALL set state IDLE, front_bank=0, swap_pending=0, clear_busy=0, last_grant=B (A wins first contention), disp_data=8'h00, previous-address register=0.
REQ-031 rst mid-CLEAR SHALL abort the sweep; partially cleared contents remain.
REQ-032 Bank contents SHALL NOT be reset; outputs SHALL be valid the first cycle after rst deasserts.

Verification
REQ-033 Reset, clear_req, wait 1024 cycles -> clear_busy high exactly 1024 cycles; swap; sweep disp_addr 0..1023 -> disp_data 8'h00 everywhere, 1 cycle behind address.
REQ-034 Both valid continuously for 4 cycles, A addr 3/data 8'hAA, B addr 4/data 8'hBB -> grants A,B,A,B; one ready per cycle; after swap, addr 3=8'hAA, addr 4=8'hBB.
REQ-035 swap_req at disp_addr=500 -> swap_pending=1; front_bank toggles on the edge disp_addr goes 1023->0; swap_pending clears then.
REQ-036 swap_req, then clear_req before boundary -> no swap at first boundary (in CLEAR); swap at first boundary after clear_busy falls.
REQ-037 clear_req with wra_valid high the same cycle -> wra_ready=0, no write; readies stay 0 for 1024 cycles.
REQ-038 rst asserted at clear cycle 300 -> clear_busy=0, front_bank=0 next cycle; wra write accepted the following cycle.

Source files
------------

// File: rtl/framebuffer_arbiter.sv
// framebuffer_arbiter: double-buffered 1024x8 framebuffer with round-robin writers, clear sweep and frame-synced swap
module framebuffer_arbiter #(
  parameter logic [7:0] CLEAR_VALUE = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] disp_addr,
  output logic [7:0] disp_data,
  input  logic       wra_valid,
  input  logic [9:0] wra_addr,
  input  logic [7:0] wra_data,
  output logic       wra_ready,
  input  logic       wrb_valid,
  input  logic [9:0] wrb_addr,
  input  logic [7:0] wrb_data,
  output logic       wrb_ready,
  input  logic       clear_req,
  output logic       clear_busy,
  input  logic       swap_req,
  output logic       swap_pending,
  output logic       front_bank
);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t     r_state, w_next;
  logic [7:0] r_mem [0:2047];
  logic [9:0] r_clr_addr, r_prev_addr, w_waddr;
  logic [7:0] r_disp, w_wdata;
  logic       r_last_b, r_front, r_pend, w_open, w_we, w_swap;
  always_comb begin
    w_next    = (r_state == IDLE) ? (clear_req ? CLEAR : IDLE) : ((r_clr_addr == 10'h3ff) ? IDLE : CLEAR);
    w_open    = !rst && r_state == IDLE && !clear_req;
    wra_ready = w_open && wra_valid && (!wrb_valid || r_last_b);
    wrb_ready = w_open && wrb_valid && (!wra_valid || !r_last_b);
    w_we      = !rst && (r_state == CLEAR || wra_ready || wrb_ready);
    w_waddr   = (r_state == CLEAR) ? r_clr_addr : (wra_ready ? wra_addr : wrb_addr);
    w_wdata   = (r_state == CLEAR) ? CLEAR_VALUE : (wra_ready ? wra_data : wrb_data);
    w_swap    = r_pend && r_state == IDLE && r_prev_addr == 10'h3ff && disp_addr == 10'h000;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_clr_addr  <= '0;
      r_prev_addr <= '0;
      r_disp      <= '0;
      r_last_b    <= 1'b1;
      r_front     <= 1'b0;
      r_pend      <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_clr_addr  <= (r_state == CLEAR) ? r_clr_addr + 10'd1 : '0;
      r_prev_addr <= disp_addr;
      r_disp      <= r_mem[{r_front, disp_addr}];
      r_last_b    <= wra_ready ? 1'b0 : (wrb_ready ? 1'b1 : r_last_b);
      r_front     <= w_swap ? ~r_front : r_front;
      r_pend      <= w_swap ? 1'b0 : (r_pend | swap_req);
    end
  end
  // Back bank is addressed with the pre-edge front index, so a write on the swap edge lands in the old back bank.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[{~r_front, w_waddr}] <= w_wdata;
  end
  assign disp_data    = r_disp;
  assign clear_busy   = (r_state == CLEAR);
  assign swap_pending = r_pend;
  assign front_bank   = r_front;
endmodule
